// File: rtl/mantis_round_iter.sv
// mantis_round_iter
//   Iterative Mantis round engine for one 64-bit state. Runs NUM_ROUNDS rounds
//   per job. Each job runs either forward (R) or inverse (R_inv). The engine
//   computes UNROLL rounds per clock. Round keys come from an external table
//   through a same-cycle indexed lookup (rk_idx -> rk).
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   in_valid/in_ready   job handshake; in_state and in_inverse are sampled at accept
//   rk_idx              per-slot round-key index (slot k = [k*IDX_W +: IDX_W]), 0 outside RUN
//   rk                  per-slot round key (slot k = [k*64 +: 64]), same cycle as rk_idx
//   out_valid/out_ready result handshake; out_state is held while not consumed
//   busy                high while rounds are being computed
module mantis_round_iter #(
    parameter int NUM_ROUNDS = 7,
    parameter int UNROLL     = 1,
    parameter int IDX_W      = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_inverse,
    input  logic [63:0]             in_state,
    output logic [UNROLL*IDX_W-1:0] rk_idx,
    input  logic [UNROLL*64-1:0]    rk,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [63:0]             out_state,
    output logic                    busy
);
    localparam int CNT_W = IDX_W + 1;

    // Nibble tables, entry i sits at bits [63-4i -: 4] (same order as the cells).
    localparam logic [63:0] SBOX     = 64'hCAD3EBF789150246;
    localparam logic [63:0] PERM     = 64'h0B6DA1C75E38F492;
    localparam logic [63:0] PERM_INV = 64'h05FAD827BE41639C;

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    fsm_t             fsm;
    logic [63:0]      st;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             inv;
    logic             accept;

    function automatic logic [3:0] nib(input logic [63:0] v, input int i);
        return v[63-4*i -: 4];
    endfunction

    function automatic logic [63:0] sub_cells(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 16; i++) y[63-4*i -: 4] = nib(SBOX, int'(nib(x, i)));
        return y;
    endfunction

    // out cell i = in cell p[i]
    function automatic logic [63:0] shuffle(input logic [63:0] x, input logic [63:0] p);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 16; i++) y[63-4*i -: 4] = nib(x, int'(nib(p, i)));
        return y;
    endfunction

    // circ(0,1,1,1): each cell becomes the XOR of the other three in its column
    function automatic logic [63:0] mix_cols(input logic [63:0] x);
        logic [63:0] y;
        logic [3:0]  s;
        y = '0;
        for (int c = 0; c < 4; c++) begin
            s = nib(x, 4*c) ^ nib(x, 4*c+1) ^ nib(x, 4*c+2) ^ nib(x, 4*c+3);
            for (int r = 0; r < 4; r++) y[63-4*(4*c+r) -: 4] = s ^ nib(x, 4*c+r);
        end
        return y;
    endfunction

    function automatic logic [63:0] fwd_round(input logic [63:0] x, input logic [63:0] k);
        return mix_cols(shuffle(sub_cells(x) ^ k, PERM));
    endfunction

    function automatic logic [63:0] inv_round(input logic [63:0] y, input logic [63:0] k);
        return sub_cells(shuffle(mix_cols(y), PERM_INV) ^ k);
    endfunction

    // Combinational chain of UNROLL rounds starting from the state register.
    logic [63:0] chain [UNROLL+1];
    assign chain[0] = st;

    for (genvar k = 0; k < UNROLL; k++) begin : g_slot
        logic [IDX_W-1:0] fwd_idx;
        // cnt + k < NUM_ROUNDS <= 2**IDX_W, so the low IDX_W bits are exact
        assign fwd_idx = cnt[IDX_W-1:0] + IDX_W'(k);
        assign rk_idx[k*IDX_W +: IDX_W] = (fsm != RUN) ? '0 :
                                          inv ? IDX_W'(NUM_ROUNDS-1) - fwd_idx : fwd_idx;
        assign chain[k+1] = inv ? inv_round(chain[k], rk[k*64 +: 64])
                                : fwd_round(chain[k], rk[k*64 +: 64]);
    end

    // Gated by rst_n so in_ready stays low for the whole reset pulse.
    assign in_ready  = rst_n && ((fsm == IDLE) || ((fsm == DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign cnt_next  = cnt + CNT_W'(UNROLL);
    assign out_state = st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm       <= IDLE;
            st        <= '0;
            cnt       <= '0;
            inv       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (fsm)
                RUN: begin
                    st  <= chain[UNROLL];
                    cnt <= cnt_next;
                    if (cnt_next == CNT_W'(NUM_ROUNDS)) begin
                        fsm       <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsm       <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
            // accept is only possible in IDLE or DONE; it overrides the DONE->IDLE move
            if (accept) begin
                st   <= in_state;
                inv  <= in_inverse;
                cnt  <= '0;
                busy <= 1'b1;
                fsm  <= RUN;
            end
        end
    end
endmodule
